softreg_prog_initiator: RTL

- Host-side initiator for the soft-register programming protocol used by the accelerator drive blocks.
- Accepts one command holding PACKET_COUNT 64-bit program words. Issues those words as soft-register writes, then issues RESP_COUNT soft-register reads.
- Collects the read responses, which carry the start and end cycle stamps, and reports start, end and elapsed cycles upstream.
- Sits between a test/host sequencer and an app's softreg_req/softreg_resp port pair, for simulation benches and on-chip self-test.

---
 rtl/ShellTypes.sv | 17 +
 rtl/softreg_init_pkg.sv | 22 ++
 rtl/softreg_resp_collector.sv | 75 +++++++
 rtl/softreg_prog_initiator.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/ShellTypes.sv
// Shared shell-side soft-register request/response types used by every app
// port and host-side initiator in the accelerator tree.
package ShellTypes;

   typedef struct packed {
      logic        valid;
      logic        isWrite;
      logic [31:0] addr;
      logic [63:0] data;
   } SoftRegReq;

   typedef struct packed {
      logic        valid;
      logic [63:0] data;
   } SoftRegResp;

endpackage

// File: rtl/softreg_init_pkg.sv
// Common definitions for the soft-register programming initiator: FSM states,
// the fixed read count per command and the default word address stride.
package softreg_init_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WRITE,
      ST_READ,
      ST_WAIT_RESP,
      ST_REPORT
   } state_t;

   localparam int READS_PER_CMD       = 2;
   localparam int DEFAULT_ADDR_STRIDE = 8;

   // Cycle stamps come from a free-running 64-bit counter, so wrap is expected.
   function automatic logic [63:0] elapsedCycles(input logic [63:0] startStamp,
                                                 input logic [63:0] endStamp);
      return endStamp - startStamp;
   endfunction

endpackage

// File: rtl/softreg_resp_collector.sv
// Tracks outstanding soft-register reads, captures in-order read data into the
// start/end stamp slots, flags unexpected responses and times out the wait.
module softreg_resp_collector
   import ShellTypes::*;
#(
   parameter int RESP_COUNT     = 2,
   parameter int TIMEOUT_W      = 32,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_clear,
   input  logic        i_readIssue,
   input  logic        i_captureEn,
   input  logic        i_waitResp,
   input  SoftRegResp  i_resp,
   output logic        o_captureDone,
   output logic        o_timeoutHit,
   output logic [63:0] o_slot0Next,
   output logic [63:0] o_slot1Next,
   output logic        o_spurious
);

   localparam int                   CNT_W    = $clog2(RESP_COUNT + 1);
   localparam logic [CNT_W-1:0]     CNT_FULL = CNT_W'(RESP_COUNT);
   localparam logic [TIMEOUT_W-1:0] TO_LAST  = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0]     r_outstanding;
   logic [CNT_W-1:0]     r_rcvCnt;
   logic [63:0]          r_slot0;
   logic [63:0]          r_slot1;
   logic [TIMEOUT_W-1:0] r_toCnt;
   logic                 r_spurious;
   logic                 w_accept;
   logic [CNT_W-1:0]     w_rcvNext;

   // A response that completes the capture beats a timeout in the same cycle.
   always_comb begin
      w_accept      = i_resp.valid && i_captureEn && (r_outstanding != '0);
      w_rcvNext     = r_rcvCnt + CNT_W'(w_accept);
      o_captureDone = (w_rcvNext == CNT_FULL);
      o_timeoutHit  = i_waitResp && (r_toCnt >= TO_LAST) && !o_captureDone;
      o_slot0Next   = (w_accept && (r_rcvCnt == CNT_W'(0))) ? i_resp.data : r_slot0;
      o_slot1Next   = (w_accept && (r_rcvCnt == CNT_W'(1))) ? i_resp.data : r_slot1;
      o_spurious    = r_spurious;
   end

   always_ff @(posedge clk) begin
      if (reset || i_clear) begin
         r_outstanding <= '0;
         r_rcvCnt      <= '0;
         r_slot0       <= '0;
         r_slot1       <= '0;
         r_toCnt       <= '0;
      end else begin
         r_outstanding <= r_outstanding + CNT_W'(i_readIssue) - CNT_W'(w_accept);
         r_rcvCnt      <= w_rcvNext;
         r_slot0       <= o_slot0Next;
         r_slot1       <= o_slot1Next;
         if (i_waitResp && (r_toCnt != '1)) begin
            r_toCnt <= r_toCnt + TIMEOUT_W'(1);
         end
      end
   end

   // Sticky across commands so late responses after an abort stay visible.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_spurious <= 1'b0;
      end else if (i_resp.valid && !w_accept) begin
         r_spurious <= 1'b1;
      end
   end

endmodule

// File: rtl/softreg_prog_initiator.sv
// Host-side initiator: writes a latched program of 64-bit words to soft
// registers, reads back start/end stamps and reports the elapsed cycle count.
module softreg_prog_initiator
   import ShellTypes::*, softreg_init_pkg::*;
#(
   parameter int          PACKET_COUNT   = 8,
   parameter int          RESP_COUNT     = READS_PER_CMD,
   parameter logic [31:0] ADDR_BASE      = 32'h0,
   parameter int          ADDR_STRIDE    = DEFAULT_ADDR_STRIDE,
   parameter int          TIMEOUT_W      = 32,
   parameter int          TIMEOUT_CYCLES = 1000000
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      i_cmd_valid,
   output logic                      o_cmd_ready,
   input  logic [64*PACKET_COUNT-1:0] i_cmd_words,
   output SoftRegReq                 o_softreg_req,
   input  SoftRegResp                i_softreg_resp,
   output logic                      o_busy,
   output logic                      o_result_valid,
   output logic [63:0]               o_start_cycle,
   output logic [63:0]               o_end_cycle,
   output logic [63:0]               o_elapsed,
   output logic                      o_timeout_err,
   output logic                      o_spurious_resp
);

   localparam int IDX_W = $clog2((PACKET_COUNT > RESP_COUNT) ? PACKET_COUNT : RESP_COUNT);
   localparam logic [IDX_W-1:0] LAST_WRITE = IDX_W'(PACKET_COUNT - 1);
   localparam logic [IDX_W-1:0] LAST_READ  = IDX_W'(RESP_COUNT - 1);

   state_t           r_state;
   state_t           w_nextState;
   logic [63:0]      r_words [PACKET_COUNT];
   logic [IDX_W-1:0] r_idx;
   logic             w_accept;
   logic             w_readIssue;
   logic             w_captureDone;
   logic             w_timeoutHit;
   logic [63:0]      w_slot0Next;
   logic [63:0]      w_slot1Next;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Requests are driven straight from state so writes and reads go out back to back.
   always_comb begin
      w_nextState    = r_state;
      w_accept       = 1'b0;
      w_readIssue    = 1'b0;
      o_cmd_ready    = 1'b0;
      o_busy         = 1'b1;
      o_result_valid = 1'b0;
      o_softreg_req  = '0;
      unique case (r_state)
         ST_IDLE: begin
            o_cmd_ready = 1'b1;
            o_busy      = 1'b0;
            if (i_cmd_valid) begin
               w_accept    = 1'b1;
               w_nextState = ST_WRITE;
            end
         end
         ST_WRITE: begin
            o_softreg_req.valid   = 1'b1;
            o_softreg_req.isWrite = 1'b1;
            o_softreg_req.addr    = ADDR_BASE + 32'(r_idx) * 32'(ADDR_STRIDE);
            o_softreg_req.data    = r_words[r_idx];
            if (r_idx == LAST_WRITE) begin
               w_nextState = ST_READ;
            end
         end
         ST_READ: begin
            o_softreg_req.valid = 1'b1;
            o_softreg_req.addr  = ADDR_BASE;
            w_readIssue         = 1'b1;
            if (r_idx == LAST_READ) begin
               w_nextState = ST_WAIT_RESP;
            end
         end
         ST_WAIT_RESP: begin
            if (w_captureDone || w_timeoutHit) begin
               w_nextState = ST_REPORT;
            end
         end
         ST_REPORT: begin
            o_result_valid = 1'b1;
            w_nextState    = ST_IDLE;
         end
         default: w_nextState = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_accept) begin
         for (int i = 0; i < PACKET_COUNT; i++) begin
            r_words[i] <= i_cmd_words[64*i +: 64];
         end
      end
   end

   // Results load on the way into REPORT so they are valid with result_valid.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_idx         <= '0;
         o_start_cycle <= '0;
         o_end_cycle   <= '0;
         o_elapsed     <= '0;
         o_timeout_err <= 1'b0;
      end else begin
         if (w_accept) begin
            r_idx <= '0;
         end else if (r_state == ST_WRITE) begin
            r_idx <= (r_idx == LAST_WRITE) ? '0 : r_idx + IDX_W'(1);
         end else if (r_state == ST_READ) begin
            r_idx <= r_idx + IDX_W'(1);
         end
         if ((r_state == ST_WAIT_RESP) && (w_nextState == ST_REPORT)) begin
            o_start_cycle <= w_slot0Next;
            o_end_cycle   <= w_slot1Next;
            o_elapsed     <= elapsedCycles(w_slot0Next, w_slot1Next);
            o_timeout_err <= w_timeoutHit;
         end
      end
   end

   softreg_resp_collector #(
      .RESP_COUNT     (RESP_COUNT),
      .TIMEOUT_W      (TIMEOUT_W),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_collector (
      .clk           (clk),
      .reset         (reset),
      .i_clear       (w_accept),
      .i_readIssue   (w_readIssue),
      .i_captureEn   ((r_state == ST_READ) || (r_state == ST_WAIT_RESP)),
      .i_waitResp    (r_state == ST_WAIT_RESP),
      .i_resp        (i_softreg_resp),
      .o_captureDone (w_captureDone),
      .o_timeoutHit  (w_timeoutHit),
      .o_slot0Next   (w_slot0Next),
      .o_slot1Next   (w_slot1Next),
      .o_spurious    (o_spurious_resp)
   );

endmodule
